sys_cmd_ctrl: RTL and testbench

- Command decoder and sequencer between the UART receive path and the register file / ALU.
- Parses byte-framed commands from the RX data synchroniser and drives register-file read/write strobes.
- Launches ALU operations and pushes response bytes into the TX FIFO toward the UART transmitter.
- Runs in the reference (REF_CLK) domain.

---
 rtl/sys_ctrl_pkg.sv | 32 +++
 rtl/sys_cmd_tx_push.sv | 50 +++++
 rtl/sys_cmd_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the command controller: FSM states, command
// opcodes and the register-file addresses that hold the ALU operands.
package sys_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_RD_ADDR,
      ST_RD_WAIT,
      ST_ALU_A,
      ST_ALU_B,
      ST_ALU_FN,
      ST_ALU_WAIT,
      ST_TX_PUSH
   } state_t;

   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int ALU_A_ADDR = 0;
   localparam int ALU_B_ADDR = 1;

   // States that are waiting for the next byte of a partially received frame.
   function automatic logic is_frame_state(input state_t s);
      return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
             (s == ST_ALU_A)   || (s == ST_ALU_B)   || (s == ST_ALU_FN);
   endfunction

endpackage

// File: rtl/sys_cmd_tx_push.sv
// Response serialiser: holds up to two bytes (low byte first) and writes
// them into the TX FIFO, stalling while the FIFO reports full. The byte
// being offered stays on data until it has actually been written.
module sys_cmd_tx_push #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  two,
   input  logic [DATA_WIDTH-1:0] lo,
   input  logic [DATA_WIDTH-1:0] hi,
   input  logic                  full,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  vld,
   output logic                  done
);

   logic                  pend;
   logic                  more;
   logic [DATA_WIDTH-1:0] hi_byte;
   logic                  write;

   // A write happens only in a cycle where a byte is pending and the FIFO has room.
   assign write = pend && !full;
   assign vld   = write;
   assign done  = write && !more;

   // Load a new response, or step to the high byte / empty after each write.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= 1'b0;
         more <= 1'b0;
         data <= '0;
      end else if (load) begin
         pend    <= 1'b1;
         more    <= two;
         data    <= lo;
         hi_byte <= hi;
      end else if (write) begin
         if (more) begin
            data <= hi_byte;
            more <= 1'b0;
         end else begin
            pend <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command decoder / sequencer between the UART RX path and the register
// file / ALU. Parses byte-framed commands, issues RF read/write strobes,
// starts ALU operations and queues response bytes for the UART TX FIFO.
// Optional build macro SYS_CMD_TIMEOUT_EN: abort a partial frame to IDLE
// after TIMEOUT_CYCLES cycles without a new byte.
module sys_cmd_ctrl
   import sys_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int FUN_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
   input  logic                    RX_D_VLD,
   input  logic [DATA_WIDTH-1:0]   RF_RdData,
   input  logic                    RF_RdData_Valid,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_Valid,
   input  logic                    TX_FIFO_FULL,
   output logic                    RF_WrEn,
   output logic                    RF_RdEn,
   output logic [ADDR_WIDTH-1:0]   RF_Address,
   output logic [DATA_WIDTH-1:0]   RF_WrData,
   output logic                    ALU_EN,
   output logic [FUN_WIDTH-1:0]    ALU_FUN,
   output logic                    CLKG_EN,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   output logic                    BUSY
);

   state_t                  state;
   state_t                  state_nxt;
   logic [ADDR_WIDTH-1:0]   addr_lat;
   logic [ADDR_WIDTH-1:0]   addr_lat_nxt;
   logic                    wr_en_nxt;
   logic                    rd_en_nxt;
   logic [ADDR_WIDTH-1:0]   address_nxt;
   logic [DATA_WIDTH-1:0]   wr_data_nxt;
   logic                    alu_en_nxt;
   logic [FUN_WIDTH-1:0]    alu_fun_nxt;
   logic                    clkg_en_nxt;
   logic                    tx_load;
   logic                    tx_two;
   logic [DATA_WIDTH-1:0]   tx_lo;
   logic [DATA_WIDTH-1:0]   tx_hi;
   logic                    tx_done;
   logic                    tmo_hit;

`ifdef SYS_CMD_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] tmo_cnt;
   logic             in_frame;

   assign in_frame = is_frame_state(state);
   assign tmo_hit  = in_frame && !RX_D_VLD && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Inter-byte counter: restarts on each byte, rests at zero outside frame states.
   always_ff @(posedge CLK) begin
      if (RST || !in_frame || RX_D_VLD) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Next-state and next-output decode; strobes default low, held outputs keep value.
   always_comb begin
      state_nxt    = state;
      addr_lat_nxt = addr_lat;
      wr_en_nxt    = 1'b0;
      rd_en_nxt    = 1'b0;
      address_nxt  = RF_Address;
      wr_data_nxt  = RF_WrData;
      alu_en_nxt   = 1'b0;
      alu_fun_nxt  = ALU_FUN;
      clkg_en_nxt  = CLKG_EN;
      tx_load      = 1'b0;
      tx_two       = 1'b0;
      tx_lo        = ALU_OUT[DATA_WIDTH-1:0];
      tx_hi        = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];

      case (state)
         ST_IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == DATA_WIDTH'(CMD_RF_WR)) begin
                  state_nxt = ST_WR_ADDR;
               end else if (RX_P_DATA == DATA_WIDTH'(CMD_RF_RD)) begin
                  state_nxt = ST_RD_ADDR;
               end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP)) begin
                  state_nxt = ST_ALU_A;
               end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) begin
                  state_nxt = ST_ALU_FN;
               end
            end
         end
         ST_WR_ADDR: begin
            if (RX_D_VLD) begin
               addr_lat_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
               state_nxt    = ST_WR_DATA;
            end
         end
         ST_WR_DATA: begin
            if (RX_D_VLD) begin
               wr_en_nxt   = 1'b1;
               address_nxt = addr_lat;
               wr_data_nxt = RX_P_DATA;
               state_nxt   = ST_IDLE;
            end
         end
         ST_RD_ADDR: begin
            if (RX_D_VLD) begin
               rd_en_nxt   = 1'b1;
               address_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
               state_nxt   = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (RF_RdData_Valid) begin
               tx_load   = 1'b1;
               tx_lo     = RF_RdData;
               state_nxt = ST_TX_PUSH;
            end
         end
         ST_ALU_A: begin
            if (RX_D_VLD) begin
               wr_en_nxt   = 1'b1;
               address_nxt = ADDR_WIDTH'(ALU_A_ADDR);
               wr_data_nxt = RX_P_DATA;
               state_nxt   = ST_ALU_B;
            end
         end
         ST_ALU_B: begin
            if (RX_D_VLD) begin
               wr_en_nxt   = 1'b1;
               address_nxt = ADDR_WIDTH'(ALU_B_ADDR);
               wr_data_nxt = RX_P_DATA;
               state_nxt   = ST_ALU_FN;
            end
         end
         ST_ALU_FN: begin
            if (RX_D_VLD) begin
               alu_en_nxt  = 1'b1;
               alu_fun_nxt = RX_P_DATA[FUN_WIDTH-1:0];
               clkg_en_nxt = 1'b1;
               state_nxt   = ST_ALU_WAIT;
            end
         end
         ST_ALU_WAIT: begin
            if (ALU_OUT_Valid) begin
               tx_load     = 1'b1;
               tx_two      = 1'b1;
               clkg_en_nxt = 1'b0;
               state_nxt   = ST_TX_PUSH;
            end
         end
         ST_TX_PUSH: begin
            if (tx_done) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // A stalled partial frame is dropped without issuing anything.
      if (tmo_hit) begin
         state_nxt = ST_IDLE;
      end
   end

   // State and registered outputs; reset clears everything, even mid-frame.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_IDLE;
         addr_lat   <= '0;
         RF_WrEn    <= 1'b0;
         RF_RdEn    <= 1'b0;
         RF_Address <= '0;
         RF_WrData  <= '0;
         ALU_EN     <= 1'b0;
         ALU_FUN    <= '0;
         CLKG_EN    <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         state      <= state_nxt;
         addr_lat   <= addr_lat_nxt;
         RF_WrEn    <= wr_en_nxt;
         RF_RdEn    <= rd_en_nxt;
         RF_Address <= address_nxt;
         RF_WrData  <= wr_data_nxt;
         ALU_EN     <= alu_en_nxt;
         ALU_FUN    <= alu_fun_nxt;
         CLKG_EN    <= clkg_en_nxt;
         BUSY       <= (state_nxt != ST_IDLE);
      end
   end

   sys_cmd_tx_push #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_tx_push (
      .clk (CLK),
      .rst (RST),
      .load(tx_load),
      .two (tx_two),
      .lo  (tx_lo),
      .hi  (tx_hi),
      .full(TX_FIFO_FULL),
      .data(TX_P_DATA),
      .vld (TX_D_VLD),
      .done(tx_done)
   );

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: table of directed commands, hand-written
// backpressure / reset / timeout sequences, and random commands checked
// against a command-level model of the expected RF, ALU and TX traffic.
module tb_sys_cmd_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  RX_P_DATA;
   logic        RX_D_VLD;
   logic [7:0]  RF_RdData;
   logic        RF_RdData_Valid;
   logic [15:0] ALU_OUT;
   logic        ALU_OUT_Valid;
   logic        TX_FIFO_FULL;
   logic        RF_WrEn;
   logic        RF_RdEn;
   logic [3:0]  RF_Address;
   logic [7:0]  RF_WrData;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic        CLKG_EN;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        BUSY;

   always #5 CLK = ~CLK;

   sys_cmd_ctrl dut (
      .CLK(CLK), .RST(RST),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
      .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid),
      .TX_FIFO_FULL(TX_FIFO_FULL),
      .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
      .RF_WrData(RF_WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
      .CLKG_EN(CLKG_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
      .BUSY(BUSY)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [29:0] outs();
      return {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
              CLKG_EN, TX_P_DATA, TX_D_VLD, BUSY};
   endfunction

   // ---------------- observed traffic ----------------
   logic [11:0] wr_q[$];
   logic [3:0]  rd_q[$];
   logic [3:0]  fun_q[$];
   logic [7:0]  tx_q[$];
   int          viol = 0;

   always @(negedge CLK) begin
      if (!RST) begin
         if (RF_WrEn)  wr_q.push_back({RF_Address, RF_WrData});
         if (RF_RdEn)  rd_q.push_back(RF_Address);
         if (ALU_EN)   fun_q.push_back(ALU_FUN);
         if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
         if (RF_WrEn && RF_RdEn) viol++;
         if (TX_D_VLD && TX_FIFO_FULL) viol++;
      end
   end

   // ---------------- environment responders ----------------
   logic [7:0]  rd_val = 8'h00;
   logic [15:0] alu_val = 16'h0000;
   int          alu_lat = 0;
   bit          alu_auto = 1'b1;
   bit          force_full = 1'b0;
   bit          rand_full = 1'b0;

   initial begin
      RF_RdData_Valid = 1'b0;
      RF_RdData = 8'h00;
      forever begin
         @(negedge CLK);
         if (RF_RdEn) begin
            @(posedge CLK); #1;
            RF_RdData = rd_val;
            RF_RdData_Valid = 1'b1;
            @(posedge CLK); #1;
            RF_RdData_Valid = 1'b0;
         end
      end
   end

   initial begin
      ALU_OUT_Valid = 1'b0;
      ALU_OUT = 16'h0000;
      forever begin
         @(negedge CLK);
         if (ALU_EN && alu_auto) begin
            repeat (alu_lat + 1) @(posedge CLK);
            #1;
            ALU_OUT = alu_val;
            ALU_OUT_Valid = 1'b1;
            @(posedge CLK); #1;
            ALU_OUT_Valid = 1'b0;
         end
      end
   end

   initial begin
      TX_FIFO_FULL = 1'b0;
      forever begin
         @(posedge CLK); #2;
         TX_FIFO_FULL = force_full || (rand_full && ($urandom_range(0, 2) == 0));
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- command vectors and reference model ----------------
   typedef struct {
      logic [3:0][7:0]  b;
      int               nb;
      logic [15:0]      resp;
      int               nwr;
      logic [1:0][11:0] wr;
      int               ntx;
      logic [1:0][7:0]  tx;
      int               fun;
      int               rd;
   } vec_t;

   function automatic vec_t mkv(input logic [7:0] b0, b1, b2, b3, input int nb,
                                input logic [15:0] resp, input int nwr,
                                input logic [11:0] w0, w1, input int ntx,
                                input logic [7:0] t0, t1, input int fun, rd);
      vec_t v;
      v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
      v.nb = nb; v.resp = resp;
      v.nwr = nwr; v.wr[0] = w0; v.wr[1] = w1;
      v.ntx = ntx; v.tx[0] = t0; v.tx[1] = t1;
      v.fun = fun; v.rd = rd;
      return v;
   endfunction

   // What a command should produce, from the command set alone.
   function automatic vec_t model(input logic [7:0] op, a, b, c, input logic [15:0] resp);
      vec_t v;
      v = mkv(op, a, b, c, 1, resp, 0, 12'h0, 12'h0, 0, 8'h0, 8'h0, -1, -1);
      case (op)
         8'hAA: begin v.nb = 3; v.nwr = 1; v.wr[0] = {a[3:0], b}; end
         8'hBB: begin v.nb = 2; v.rd = int'(a[3:0]); v.ntx = 1; v.tx[0] = resp[7:0]; end
         8'hCC: begin
            v.nb = 4; v.nwr = 2; v.wr[0] = {4'd0, a}; v.wr[1] = {4'd1, b};
            v.fun = int'(c[3:0]); v.ntx = 2; v.tx[0] = resp[7:0]; v.tx[1] = resp[15:8];
         end
         8'hDD: begin
            v.nb = 2; v.fun = int'(a[3:0]); v.ntx = 2; v.tx[0] = resp[7:0]; v.tx[1] = resp[15:8];
         end
         default: v.nb = 1;
      endcase
      return v;
   endfunction

   task automatic clear_q();
      wr_q.delete(); rd_q.delete(); fun_q.delete(); tx_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] d, input int gap);
      RX_P_DATA = d;
      RX_D_VLD  = 1'b1;
      @(posedge CLK); #1;
      RX_D_VLD  = 1'b0;
      repeat (gap) begin @(posedge CLK); #1; end
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      repeat (2) begin @(posedge CLK); #1; end
      while (BUSY && k < 300) begin @(posedge CLK); #1; k++; end
      chk($sformatf("%s busy_end", tag), int'(BUSY), 0);
      @(posedge CLK); #1;
   endtask

   task automatic run_vec(input vec_t v, input string tag, input int gapmax, input bit junk);
      clear_q();
      rd_val  = v.resp[7:0];
      alu_val = v.resp;
      alu_lat = $urandom_range(0, 3);
      for (int i = 0; i < v.nb; i++)
         send_byte(v.b[i], (i == v.nb - 1) ? 0 : $urandom_range(0, gapmax));
      if (junk) send_byte(8'hAA, 0);
      wait_idle(tag);
      chk($sformatf("%s wr_count", tag), wr_q.size(), v.nwr);
      for (int i = 0; i < v.nwr && i < wr_q.size(); i++)
         chk($sformatf("%s wr%0d", tag, i), int'(wr_q[i]), int'(v.wr[i]));
      chk($sformatf("%s rd_count", tag), rd_q.size(), (v.rd >= 0) ? 1 : 0);
      if (v.rd >= 0 && rd_q.size() > 0)
         chk($sformatf("%s rd_addr", tag), int'(rd_q[0]), v.rd);
      chk($sformatf("%s alu_count", tag), fun_q.size(), (v.fun >= 0) ? 1 : 0);
      if (v.fun >= 0 && fun_q.size() > 0)
         chk($sformatf("%s alu_fun", tag), int'(fun_q[0]), v.fun);
      chk($sformatf("%s tx_count", tag), tx_q.size(), v.ntx);
      for (int i = 0; i < v.ntx && i < tx_q.size(); i++)
         chk($sformatf("%s tx%0d", tag, i), int'(tx_q[i]), int'(v.tx[i]));
   endtask

   vec_t tbl[8];

   initial begin
      tbl[0] = mkv(8'hAA, 8'h05, 8'h3C, 8'h00, 3, 16'h0000, 1, 12'h53C, 12'h000, 0, 8'h00, 8'h00, -1, -1);
      tbl[1] = mkv(8'hBB, 8'h05, 8'h00, 8'h00, 2, 16'h003C, 0, 12'h000, 12'h000, 1, 8'h3C, 8'h00, -1, 5);
      tbl[2] = mkv(8'hCC, 8'h10, 8'h20, 8'h00, 4, 16'h0030, 2, 12'h010, 12'h120, 2, 8'h30, 8'h00, 0, -1);
      tbl[3] = mkv(8'hDD, 8'h02, 8'h00, 8'h00, 2, 16'h1234, 0, 12'h000, 12'h000, 2, 8'h34, 8'h12, 2, -1);
      tbl[4] = mkv(8'h55, 8'h00, 8'h00, 8'h00, 1, 16'h0000, 0, 12'h000, 12'h000, 0, 8'h00, 8'h00, -1, -1);
      tbl[5] = mkv(8'hAA, 8'hF7, 8'h81, 8'h00, 3, 16'h0000, 1, 12'h781, 12'h000, 0, 8'h00, 8'h00, -1, -1);
      tbl[6] = mkv(8'hDD, 8'hFE, 8'h00, 8'h00, 2, 16'hBEEF, 0, 12'h000, 12'h000, 2, 8'hEF, 8'hBE, 14, -1);
      tbl[7] = mkv(8'hBB, 8'h1A, 8'h00, 8'h00, 2, 16'h00C3, 0, 12'h000, 12'h000, 1, 8'hC3, 8'h00, -1, 10);

      RST = 1'b1; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset outputs", int'(outs()), 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (2) begin @(posedge CLK); #1; end

      // directed table
      for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i), 2, 1'b0);

      // result held off by a full TX FIFO for five cycles
      clear_q();
      alu_auto = 1'b0;
      send_byte(8'hDD, 0);
      send_byte(8'h02, 0);
      @(negedge CLK);
      chk("fb alu_start", int'({ALU_EN, CLKG_EN, ALU_FUN}), int'({1'b1, 1'b1, 4'd2}));
      @(posedge CLK); #1;
      ALU_OUT = 16'hA55A; ALU_OUT_Valid = 1'b1; force_full = 1'b1;
      @(negedge CLK);
      chk("fb clkg_wait", int'({ALU_EN, CLKG_EN}), int'({1'b0, 1'b1}));
      @(posedge CLK); #1;
      ALU_OUT_Valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk($sformatf("fb hold%0d", i), int'({TX_D_VLD, TX_P_DATA, CLKG_EN, BUSY}),
             int'({1'b0, 8'h5A, 1'b0, 1'b1}));
         @(posedge CLK); #1;
      end
      force_full = 1'b0;
      wait_idle("fb");
      chk("fb tx_count", tx_q.size(), 2);
      if (tx_q.size() == 2) chk("fb tx_bytes", int'({tx_q[0], tx_q[1]}), 16'h5AA5);
      alu_auto = 1'b1;

      // reset in the middle of a write frame discards it
      clear_q();
      send_byte(8'hAA, 0);
      send_byte(8'h03, 0);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("midreset outputs", int'(outs()), 0);
      @(posedge CLK); #1;
      send_byte(8'h3C, 0);
      wait_idle("midreset");
      chk("midreset no_write", wr_q.size(), 0);

`ifdef SYS_CMD_TIMEOUT_EN
      // stalled write frame times out; the late byte is then an unknown opcode
      clear_q();
      send_byte(8'hAA, 0);
      repeat (1024) begin @(posedge CLK); #1; end
      send_byte(8'h07, 0);
      repeat (3) begin @(posedge CLK); #1; end
      chk("timeout busy", int'(BUSY), 0);
      chk("timeout no_write", wr_q.size(), 0);
`endif

      // random commands with random FIFO backpressure
      rand_full = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic [7:0] op, a, b, c;
         logic [15:0] resp;
         int kind;
         vec_t v;
         kind = $urandom_range(0, 4);
         case (kind)
            0: op = 8'hAA;
            1: op = 8'hBB;
            2: op = 8'hCC;
            3: op = 8'hDD;
            default: begin
               op = 8'($urandom_range(0, 255));
               while (op == 8'hAA || op == 8'hBB || op == 8'hCC || op == 8'hDD)
                  op = 8'($urandom_range(0, 255));
            end
         endcase
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         c = 8'($urandom_range(0, 255));
         resp = 16'($urandom_range(0, 65535));
         v = model(op, a, b, c, resp);
         run_vec(v, $sformatf("rnd%0d", n), 3, (kind >= 1 && kind <= 3));
      end
      rand_full = 1'b0;
      repeat (2) begin @(posedge CLK); #1; end

      chk("strobe invariants", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
